// File: rtl/iob_cache_write_buffer_pkg.sv
// Shared sizing helpers for the cache write-through buffer.
// An entry is packed as {word address, write data, byte strobes}.
package iob_cache_write_buffer_pkg;

    function automatic int nbytes_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int wbuf_entry_w(input int addr_w, input int data_w);
        return (addr_w - nbytes_w(data_w)) + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/iob_cache_write_buffer_if.sv
// Front-end write path, write-channel head port and status of the write buffer.
// master = controller/channel side, slave = the buffer itself.
interface iob_cache_write_buffer_if
    import iob_cache_write_buffer_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 2
);
    localparam int NBYTES   = DATA_W / 8;
    localparam int NBYTES_W = nbytes_w(DATA_W);

    logic                       in_valid;
    logic [ADDR_W-NBYTES_W-1:0] in_addr;
    logic [DATA_W-1:0]          in_wdata;
    logic [NBYTES-1:0]          in_wstrb;
    logic                       in_ready;

    logic                       out_valid;
    logic [ADDR_W-NBYTES_W-1:0] out_addr;
    logic [DATA_W-1:0]          out_wdata;
    logic [NBYTES-1:0]          out_wstrb;
    logic                       out_ready;

    logic                       empty;
    logic                       full;
    logic [DEPTH_W:0]           level;

    modport master (
        output in_valid, in_addr, in_wdata, in_wstrb, out_ready,
        input  in_ready, out_valid, out_addr, out_wdata, out_wstrb, empty, full, level
    );

    modport slave (
        input  in_valid, in_addr, in_wdata, in_wstrb, out_ready,
        output in_ready, out_valid, out_addr, out_wdata, out_wstrb, empty, full, level
    );
endinterface

// File: rtl/iob_cache_wbuf_mem.sv
// Write-buffer storage: DEPTH x WIDTH register file, synchronous write,
// asynchronous read, deliberately left unreset.
module iob_cache_wbuf_mem #(
    parameter int DEPTH_W = 2,
    parameter int WIDTH   = 66
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);
    logic [WIDTH-1:0] mem_q [2**DEPTH_W];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/iob_cache_write_buffer.sv
// Write-through FIFO between the cache write path and the AXI write channel.
// The head is launched on the first out_ready and popped on the next one.
module iob_cache_write_buffer
    import iob_cache_write_buffer_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 2
) (
    input logic                   clk,
    input logic                   reset,
    iob_cache_write_buffer_if.slave wb
);
    localparam int NBYTES   = DATA_W / 8;
    localparam int WA_W     = ADDR_W - nbytes_w(DATA_W);
    localparam int ENTRY_W  = wbuf_entry_w(ADDR_W, DATA_W);
    localparam int DATA_LSB = NBYTES;
    localparam int ADDR_LSB = NBYTES + DATA_W;
    localparam logic [DEPTH_W:0] FULL_LVL = {1'b1, {DEPTH_W{1'b0}}};

    logic [DEPTH_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_W:0]   level_q, level_d;
    logic               inflight_q, inflight_d;
    logic               full, empty, out_valid;
    logic               push, launch, complete;
    logic [ENTRY_W-1:0] wr_entry, rd_entry, head;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    // While in flight, out_valid announces a further entry queued behind the head.
    assign out_valid = inflight_q ? (|level_q[DEPTH_W:1]) : ~empty;

    assign wr_entry = {wb.in_addr, wb.in_wdata, wb.in_wstrb};
    assign head     = empty ? '0 : rd_entry;

    assign wb.in_ready  = ~full;
    assign wb.out_valid = out_valid;
    assign wb.out_addr  = head[ADDR_LSB +: WA_W];
    assign wb.out_wdata = head[DATA_LSB +: DATA_W];
    assign wb.out_wstrb = head[0 +: NBYTES];
    assign wb.empty     = empty;
    assign wb.full      = full;
    assign wb.level     = level_q;

    always_comb begin
        push       = wb.in_valid & ~full;
        launch     = ~inflight_q & out_valid & wb.out_ready;
        complete   = inflight_q & wb.out_ready;
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = complete ? rptr_q + 1'b1 : rptr_q;
        level_d    = level_q;
        case ({push, complete})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        inflight_d = inflight_q;
        if (launch) inflight_d = 1'b1;
        // Back-to-back: the next entry is already in its address phase.
        else if (complete) inflight_d = |level_q[DEPTH_W:1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
        end
    end

    iob_cache_wbuf_mem #(
        .DEPTH_W (DEPTH_W),
        .WIDTH   (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (wr_entry),
        .raddr (rptr_q),
        .rdata (rd_entry)
    );
endmodule
